mul_mac_unit: RTL

MUL_MAC_UNIT -- requirements
Module: mul_mac_unit

---
 rtl/mul_mac_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mul_mac_unit.sv
// Iterative multiply / multiply-accumulate unit. Consumes the multiplier in
// four DATA_W/4-bit chunks (one per CALC cycle), then completes in DONE.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   alu_control, start    op code and request (sampled in IDLE)
//   operand_a, operand_b  multiplicand / multiplier
//   flush, acc_clr        abort in-flight op / clear accumulator
//   result, done          result (valid with done) and 1-cycle done pulse
//   stall, acc_out        ID/EX hold request and accumulator value
module mul_mac_unit #(
   parameter int         DATA_W = 64,
   parameter logic [3:0] MUL_OP = 4'd8,
   parameter logic [3:0] MAC_OP = 4'd9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        alu_control,
   input  logic              start,
   input  logic [DATA_W-1:0] operand_a,
   input  logic [DATA_W-1:0] operand_b,
   input  logic              flush,
   input  logic              acc_clr,
   output logic [DATA_W-1:0] result,
   output logic              done,
   output logic              stall,
   output logic [DATA_W-1:0] acc_out
);
   localparam int Q  = DATA_W / 4;
   localparam int SW = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state;
   state_t            state_nx;
   logic [1:0]        step;
   logic              is_mac;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] prod;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] res_q;

   logic              op_ok;
   logic              accept;
   logic [SW-1:0]     shamt;
   logic [Q-1:0]      chunk;
   logic [DATA_W-1:0] pp;
   logic [DATA_W-1:0] fin;

   assign op_ok  = (alu_control == MUL_OP) || (alu_control == MAC_OP);
   assign accept = (state == IDLE) && start && op_ok && !flush;

   // Bit offset of the multiplier chunk handled in the current step.
   always_comb begin
      shamt = '0;
      unique case (step)
         2'd0:    shamt = '0;
         2'd1:    shamt = SW'(Q);
         2'd2:    shamt = SW'(2 * Q);
         default: shamt = SW'(3 * Q);
      endcase
   end

   assign chunk = Q'(b_q >> shamt);
   assign pp    = (a_q * {{(DATA_W-Q){1'b0}}, chunk}) << shamt;
   assign fin   = is_mac ? acc + prod : prod;

   // done is squashed by flush/rst so an aborted op never reports.
   assign done    = (state == DONE) && !flush && !rst;
   assign stall   = !rst && (accept || (state == CALC));
   assign result  = done ? fin : res_q;
   assign acc_out = acc;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = CALC;
         CALC:    if (step == 2'd3) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         step   <= '0;
         is_mac <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         prod   <= '0;
         acc    <= '0;
         res_q  <= '0;
      end else begin
         if (accept) begin
            a_q    <= operand_a;
            b_q    <= operand_b;
            is_mac <= (alu_control == MAC_OP);
            prod   <= '0;
            step   <= '0;
         end
         if (state == CALC) begin
            prod <= prod + pp;
            step <= step + 2'd1;
         end
         if (flush) begin
            prod <= '0;
            step <= '0;
         end
         if (done) begin
            res_q <= fin;
            if (is_mac) acc <= fin;
         end
         // Clear wins over a coincident MAC write-back.
         if (acc_clr) acc <= '0;
      end
   end

endmodule
